// File: rtl/ecc_scrub_pkg.sv
// ecc_scrub_pkg: shared enums and parametrised SEC-DED helpers for the scrubbed shift register
package ecc_scrub_pkg;
  typedef enum logic [1:0] {MODE_SISO_R = 2'b00, MODE_SISO_L = 2'b01, MODE_PISO = 2'b10, MODE_PIPO = 2'b11} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} scrub_state_e;
  function automatic int check_bits(input int sw);
    int r = 0;
    while ((1 << r) < sw + r + 1) r++;
    return r + 1;
  endfunction
  // Hamming position of data bit k: the k-th position that is not a power of two
  function automatic logic [5:0] data_pos(input int k);
    int n = 0;
    logic [5:0] pos = '0;
    for (int p = 3; p < 64; p++)
      if ((p & (p - 1)) != 0) begin
        if (n == k) pos = 6'(p);
        n++;
      end
    return pos;
  endfunction
  function automatic logic [5:0] hamming(input logic [31:0] d, input int sw);
    logic [5:0] s = '0;
    for (int k = 0; k < 32; k++) if (k < sw && d[k]) s ^= data_pos(k);
    return s;
  endfunction
  // Packs Hamming bits low and the overall parity bit directly above them
  function automatic logic [6:0] secded_encode(input logic [31:0] d, input int sw);
    int r = check_bits(sw) - 1;
    logic [5:0] h = hamming(d, sw);
    return 7'(h) | (7'(^d ^ ^h) << r);
  endfunction
  // Returns {overall parity mismatch, syndrome}
  function automatic logic [6:0] secded_syndrome(input logic [31:0] d, input logic [6:0] c, input int sw);
    logic [5:0] m = 6'((1 << (check_bits(sw) - 1)) - 1);
    return {^d ^ ^c, hamming(d, sw) ^ (c[5:0] & m)};
  endfunction
endpackage

// File: rtl/secded_seg.sv
// secded_seg: combinational SEC-DED decoder for one segment
module secded_seg import ecc_scrub_pkg::*; #(
  parameter int SEG_W = 8,
  localparam int CB = check_bits(SEG_W)
) (
  input  logic [SEG_W-1:0] data,
  input  logic [CB-1:0]    check,
  output logic [SEG_W-1:0] corrected,
  output logic             single,
  output logic             double
);
  logic [6:0] sv;
  assign sv = secded_syndrome(32'(data), 7'(check), SEG_W);
  assign single = sv[6];
  assign double = !sv[6] && |sv[5:0];
  for (genvar k = 0; k < SEG_W; k++) begin : g_cor
    assign corrected[k] = data[k] ^ (single && sv[5:0] == data_pos(k));
  end
endmodule

// File: rtl/ecc_shift_reg_scrub.sv
// ecc_shift_reg_scrub: segmented SEC-DED shift register with background scrubbing
module ecc_shift_reg_scrub import ecc_scrub_pkg::*; #(
  parameter int WIDTH = 128,
  parameter int SEG_W = 8,
  parameter int CNT_W = 16,
  localparam int NSEG = WIDTH / SEG_W,
  localparam int PW = $clog2(WIDTH),
  localparam int SW = $clog2(NSEG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic [WIDTH-1:0] parallel_out,
  input  logic             scrub_en,
  input  logic             scrub_cont,
  input  logic             inj_en,
  input  logic [PW-1:0]    inj_pos,
  input  logic             clr_status,
  output logic             err_single,
  output logic [CNT_W-1:0] err_corr_cnt,
  output logic             err_uncorr,
  output logic [SW-1:0]    uncorr_seg,
  output logic             scrub_done
);
  localparam int CB = check_bits(SEG_W);
  logic [WIDTH-1:0] data, data_d, data_next, corr;
  logic [NSEG-1:0][SEG_W-1:0] corr_seg;
  logic [NSEG-1:0][CB-1:0] check, check_d, enc_next;
  logic [NSEG-1:0] single, dbl;
  scrub_state_e state, state_d;
  logic [SW-1:0] ptr, ptr_d, inj_seg;
  logic [CB-1:0] seg_enc;
  logic act, wb, dbl_hit;
  for (genvar s = 0; s < NSEG; s++) begin : g_seg
    secded_seg #(.SEG_W(SEG_W)) u_dec (
      .data(data[s*SEG_W +: SEG_W]), .check(check[s]), .corrected(corr_seg[s]),
      .single(single[s]), .double(dbl[s])
    );
    assign enc_next[s] = CB'(secded_encode(32'(data_next[s*SEG_W +: SEG_W]), SEG_W));
  end
  assign corr = corr_seg;
  assign parallel_out = corr;
  assign serial_out = (mode == MODE_SISO_R || mode == MODE_PISO) ? corr[0] : corr[WIDTH-1];
  assign err_single = |single;
  assign scrub_done = state == S_DONE;
  assign data_next = mode == MODE_SISO_R ? {serial_in, corr[WIDTH-1:1]} :
                     mode == MODE_SISO_L ? {corr[WIDTH-2:0], serial_in} :
                     load ? parallel_in :
                     mode == MODE_PISO ? {1'b0, corr[WIDTH-1:1]} : corr;
  assign inj_seg = SW'(inj_pos >> $clog2(SEG_W));
  assign seg_enc = CB'(secded_encode(32'(corr_seg[ptr]), SEG_W));
  assign act = state == S_SCAN && scrub_en && !enable;
  // A same-cycle injection into the visited segment wins over its write-back
  assign wb = act && single[ptr] && !(inj_en && inj_seg == ptr);
  assign dbl_hit = act && dbl[ptr];
  always_comb begin
    data_d = enable ? data_next : data;
    check_d = enable ? enc_next : check;
    if (!enable && inj_en) data_d[inj_pos] = ~data[inj_pos];
    if (wb) begin
      data_d[ptr*SEG_W +: SEG_W] = corr_seg[ptr];
      check_d[ptr] = seg_enc;
    end
  end
  always_comb begin
    state_d = state;
    ptr_d = ptr;
    case (state)
      S_IDLE: if (scrub_en) begin
        state_d = S_SCAN;
        ptr_d = '0;
      end
      S_SCAN: if (!scrub_en) state_d = S_IDLE;
        else if (!enable) begin
          if (ptr == SW'(NSEG - 1)) state_d = S_DONE;
          else ptr_d = ptr + 1'b1;
        end
      S_DONE: begin
        state_d = (scrub_cont && scrub_en) ? S_SCAN : S_IDLE;
        ptr_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      data <= '0;
      check <= '0;
      state <= S_IDLE;
      ptr <= '0;
      err_corr_cnt <= '0;
      err_uncorr <= 1'b0;
      uncorr_seg <= '0;
    end else begin
      data <= data_d;
      check <= check_d;
      state <= state_d;
      ptr <= ptr_d;
      err_corr_cnt <= clr_status ? '0 : (wb && !(&err_corr_cnt)) ? err_corr_cnt + 1'b1 : err_corr_cnt;
      err_uncorr <= !clr_status && (err_uncorr || dbl_hit);
      uncorr_seg <= clr_status ? '0 : (dbl_hit && !err_uncorr) ? ptr : uncorr_seg;
    end
endmodule

// File: tb/tb_ecc_shift_reg_scrub.sv
// tb_ecc_shift_reg_scrub: directed scenario bench for the scrubbed ECC shift register
module tb_ecc_shift_reg_scrub;
  localparam logic [127:0] V = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  logic clk, rst, enable, load, serial_in, scrub_en, scrub_cont, inj_en, clr_status;
  logic [1:0] mode;
  logic [127:0] parallel_in, parallel_out;
  logic serial_out, err_single, err_uncorr, scrub_done;
  logic [6:0] inj_pos;
  logic [15:0] err_corr_cnt;
  logic [3:0] uncorr_seg;
  int passed = 0, total = 0, cyc, ph, n;

  ecc_shift_reg_scrub #(.WIDTH(128), .SEG_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .load(load), .serial_in(serial_in),
    .parallel_in(parallel_in), .serial_out(serial_out), .parallel_out(parallel_out),
    .scrub_en(scrub_en), .scrub_cont(scrub_cont), .inj_en(inj_en), .inj_pos(inj_pos),
    .clr_status(clr_status), .err_single(err_single), .err_corr_cnt(err_corr_cnt),
    .err_uncorr(err_uncorr), .uncorr_seg(uncorr_seg), .scrub_done(scrub_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr;
    clr_status = 1'b1;
    tick;
    clr_status = 1'b0;
  endtask

  task automatic run_pass(output int c);
    scrub_en = 1'b1;
    c = 0;
    do begin
      tick;
      c++;
    end while (!scrub_done && c < 200);
    scrub_en = 1'b0;
    tick;
  endtask

  task automatic load_pipo(input logic [127:0] v);
    mode = 2'b11; load = 1'b1; parallel_in = v; enable = 1'b1;
    tick;
    enable = 1'b0; load = 1'b0;
  endtask

  task automatic inject(input logic [6:0] p);
    inj_en = 1'b1; inj_pos = p;
    tick;
    inj_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; enable = 0; load = 0; serial_in = 0; scrub_en = 0; scrub_cont = 0;
    inj_en = 0; clr_status = 0; mode = 2'b00; parallel_in = '0; inj_pos = '0;
    repeat (3) tick;
    total++; if (parallel_out !== '0) $display("FAIL reset_pout: got %h expected 0", parallel_out); else passed++;
    total++; if (serial_out !== 1'b0) $display("FAIL reset_sout: got %b expected 0", serial_out); else passed++;
    total++; if ({err_single, err_uncorr, scrub_done} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {err_single, err_uncorr, scrub_done}); else passed++;
    total++; if ({err_corr_cnt, uncorr_seg} !== 20'h0) $display("FAIL reset_cnt: got %h expected 0", {err_corr_cnt, uncorr_seg}); else passed++;
    rst = 1'b1;
    tick;
    run_pass(cyc);
    total++; if (cyc !== 17) $display("FAIL clean_pass_len: got %0d expected 17", cyc); else passed++;
    total++; if (err_corr_cnt !== 16'h0) $display("FAIL clean_pass_cnt: got %h expected 0", err_corr_cnt); else passed++;
  endtask

  task automatic test_single;
    load_pipo(V);
    total++; if (parallel_out !== V) $display("FAIL pipo_load: got %h expected %h", parallel_out, V); else passed++;
    inject(7'd5);
    total++; if (parallel_out !== V) $display("FAIL single_corr_view: got %h expected %h", parallel_out, V); else passed++;
    total++; if (err_single !== 1'b1) $display("FAIL single_flag: got %b expected 1", err_single); else passed++;
    run_pass(cyc);
    total++; if (err_corr_cnt !== 16'd1) $display("FAIL single_scrub_cnt: got %0d expected 1", err_corr_cnt); else passed++;
    total++; if (err_single !== 1'b0) $display("FAIL single_healed: got %b expected 0", err_single); else passed++;
  endtask

  task automatic test_double;
    pulse_clr;
    total++; if (err_corr_cnt !== 16'd0) $display("FAIL clr_cnt: got %0d expected 0", err_corr_cnt); else passed++;
    inject(7'd0);
    inject(7'd1);
    total++; if (parallel_out[7:0] !== 8'h13) $display("FAIL double_raw: got %h expected 13", parallel_out[7:0]); else passed++;
    total++; if (parallel_out[127:8] !== V[127:8]) $display("FAIL double_rest: got %h expected %h", parallel_out[127:8], V[127:8]); else passed++;
    run_pass(cyc);
    total++; if (err_uncorr !== 1'b1) $display("FAIL double_sticky: got %b expected 1", err_uncorr); else passed++;
    total++; if (uncorr_seg !== 4'd0) $display("FAIL double_seg: got %0d expected 0", uncorr_seg); else passed++;
    total++; if (err_corr_cnt !== 16'd0) $display("FAIL double_cnt: got %0d expected 0", err_corr_cnt); else passed++;
    inject(7'd24);
    inject(7'd25);
    run_pass(cyc);
    total++; if (uncorr_seg !== 4'd0) $display("FAIL double_first_kept: got %0d expected 0", uncorr_seg); else passed++;
    pulse_clr;
    total++; if ({err_uncorr, uncorr_seg} !== 5'd0) $display("FAIL double_clr: got %b expected 00000", {err_uncorr, uncorr_seg}); else passed++;
  endtask

  task automatic test_shift_modes;
    load_pipo(128'd1);
    mode = 2'b00;
    inject(7'd0);
    total++; if (serial_out !== 1'b1) $display("FAIL siso_r_sout_corr: got %b expected 1", serial_out); else passed++;
    total++; if (err_single !== 1'b1) $display("FAIL siso_r_err: got %b expected 1", err_single); else passed++;
    serial_in = 1'b0; enable = 1'b1;
    tick;
    enable = 1'b0;
    total++; if (parallel_out !== 128'd0) $display("FAIL siso_r_shift: got %h expected 0", parallel_out); else passed++;
    total++; if (err_single !== 1'b0) $display("FAIL siso_r_heal: got %b expected 0", err_single); else passed++;
    total++; if (err_corr_cnt !== 16'd0) $display("FAIL siso_r_cnt: got %0d expected 0", err_corr_cnt); else passed++;
    load_pipo({1'b1, 126'd0, 1'b1});
    mode = 2'b01;
    total++; if (serial_out !== 1'b1) $display("FAIL siso_l_sout: got %b expected 1", serial_out); else passed++;
    serial_in = 1'b1; enable = 1'b1;
    tick;
    enable = 1'b0; serial_in = 1'b0;
    total++; if (parallel_out !== 128'd3) $display("FAIL siso_l_shift: got %h expected 3", parallel_out); else passed++;
    mode = 2'b10; load = 1'b1; parallel_in = V; enable = 1'b1;
    tick;
    load = 1'b0;
    tick;
    enable = 1'b0;
    total++; if (parallel_out !== (V >> 1)) $display("FAIL piso_shift: got %h expected %h", parallel_out, V >> 1); else passed++;
  endtask

  task automatic test_pause;
    load_pipo(V);
    pulse_clr;
    scrub_en = 1'b1;
    cyc = 0;
    do begin
      if (cyc == 8) begin
        enable = 1'b1; mode = 2'b11; load = 1'b0; inj_en = 1'b1; inj_pos = 7'd3;
      end
      tick;
      cyc++;
      enable = 1'b0; inj_en = 1'b0;
    end while (!scrub_done && cyc < 200);
    scrub_en = 1'b0;
    tick;
    total++; if (cyc !== 18) $display("FAIL pause_pass_len: got %0d expected 18", cyc); else passed++;
    total++; if (err_single !== 1'b0) $display("FAIL pause_inj_dropped: got %b expected 0", err_single); else passed++;
    total++; if (parallel_out !== V) $display("FAIL pause_data: got %h expected %h", parallel_out, V); else passed++;
    total++; if (err_corr_cnt !== 16'd0) $display("FAIL pause_cnt: got %0d expected 0", err_corr_cnt); else passed++;
  endtask

  task automatic test_saturate_and_reset;
    pulse_clr;
    scrub_cont = 1'b1; scrub_en = 1'b1;
    inj_en = 1'b1; inj_pos = 7'd0;
    tick;
    ph = 0; n = 0;
    // Each cycle plants an error in the segment the scrubber visits next
    while (err_corr_cnt !== 16'hFFFF && n < 75000) begin
      inj_en = ph < 16;
      inj_pos = 7'(((ph + 1) % 16) * 8);
      tick;
      ph = (ph + 1) % 17;
      n++;
    end
    total++; if (err_corr_cnt !== 16'hFFFF) $display("FAIL sat_reach: got %h expected ffff", err_corr_cnt); else passed++;
    repeat (40) begin
      inj_en = ph < 16;
      inj_pos = 7'(((ph + 1) % 16) * 8);
      tick;
      ph = (ph + 1) % 17;
    end
    inj_en = 1'b0;
    total++; if (err_corr_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", err_corr_cnt); else passed++;
    total++; if (parallel_out !== V) $display("FAIL sat_data: got %h expected %h", parallel_out, V); else passed++;
    scrub_cont = 1'b0; scrub_en = 1'b0;
    tick;
    scrub_en = 1'b1;
    repeat (5) tick;
    rst = 1'b0;
    #2;
    total++; if (parallel_out !== '0 || serial_out !== 1'b0) $display("FAIL rst_mid_data: got %h/%b expected 0/0", parallel_out, serial_out); else passed++;
    total++; if ({err_single, err_uncorr, scrub_done, err_corr_cnt, uncorr_seg} !== 23'd0) $display("FAIL rst_mid_status: got %h expected 0", {err_single, err_uncorr, scrub_done, err_corr_cnt, uncorr_seg}); else passed++;
    scrub_en = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    run_pass(cyc);
    total++; if (cyc !== 17) $display("FAIL rst_then_pass: got %0d expected 17", cyc); else passed++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_double;
    test_shift_modes;
    test_pause;
    test_saturate_and_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
